// File: rtl/dtag_ctl.sv
// Data-cache tag controller: tag lookup/compare, tag writes (init, dirty-set, allocate, flush sweep),
// victim writeback and linefill handshakes toward the bus unit.
// Latency: hit -> req_done in the cycle after LOOKUP (one lookup per 2 cycles); miss adds wb + lf + 1 cycle.
// Backpressure: busy=1 outside IDLE; req/flush_req are only accepted in IDLE, the requester holds them.
//
// Ports:
//   nGCLK, RESET              clock (posedge), asynchronous active-high reset
//   req/req_wr/req_addr       lookup request from the D-side pipeline
//   flush_req                 clean+invalidate whole cache (wins over req)
//   busy, req_done, req_hit   status; req_done/req_hit and flush_done are one-cycle pulses
//   tag_rd_sel/tag_rd_data    dtag read port (data valid the cycle after sel is clocked)
//   tag_wr_sel/_data/_ena     dtag write port
//   wb_req/wb_addr/wb_ack     victim writeback handshake
//   lf_req/lf_addr/lf_ack     linefill handshake
module dtag_ctl #(
   parameter int NL  = 256,
   parameter int LSS = 8,
   parameter int LSH = LSS + 4,
   parameter int PSL = LSH + 1,
   parameter int TS  = 2 + (32 - PSL)
) (
   input  logic            nGCLK,
   input  logic            RESET,
   input  logic            req,
   input  logic            req_wr,
   input  logic [31:0]     req_addr,
   input  logic            flush_req,
   output logic            busy,
   output logic            req_done,
   output logic            req_hit,
   output logic            flush_done,
   output logic [LSS-1:0]  tag_rd_sel,
   input  logic [TS-1:0]   tag_rd_data,
   output logic [LSS-1:0]  tag_wr_sel,
   output logic [TS-1:0]   tag_wr_data,
   output logic            tag_wr_ena,
   output logic            wb_req,
   output logic [31:0]     wb_addr,
   input  logic            wb_ack,
   output logic            lf_req,
   output logic [31:0]     lf_addr,
   input  logic            lf_ack
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_LOOKUP, S_WB, S_LF, S_ALLOC,
      S_FL_RD, S_FL_CHK, S_FL_WB, S_FL_INV
   } state_t;

   state_t          state, state_nxt;
   logic [LSS-1:0]  index, index_nxt;
   logic [31:0]     cap_addr;
   logic            cap_wr;
   logic            cap_ld;
   logic            wb_ld;
   logic [31:0]     wb_ld_addr;
   logic            done_nxt, hit_nxt, fdone_nxt;

   // Field views of the returned tag entry and of the captured request.
   logic             rd_v, rd_d;
   logic [TS-3:0]    rd_tag;
   logic [TS-3:0]    cap_tag;
   logic [LSS-1:0]   cap_idx;
   logic             tag_match;

   assign rd_v      = tag_rd_data[TS-1];
   assign rd_d      = tag_rd_data[TS-2];
   assign rd_tag    = tag_rd_data[TS-3:0];
   assign cap_tag   = cap_addr[31:PSL];
   assign cap_idx   = cap_addr[LSH:5];
   assign tag_match = rd_v && (rd_tag == cap_tag);

   assign busy    = (state != S_IDLE);
   // Masking the offset keeps the fill address line-aligned.
   assign lf_addr = cap_addr & ~32'h0000_001F;

   always_ff @(posedge nGCLK or posedge RESET) begin
      if (RESET) begin
         state      <= S_INIT;
         index      <= '0;
         cap_addr   <= '0;
         cap_wr     <= 1'b0;
         wb_addr    <= '0;
         req_done   <= 1'b0;
         req_hit    <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         index      <= index_nxt;
         req_done   <= done_nxt;
         req_hit    <= hit_nxt;
         flush_done <= fdone_nxt;
         if (cap_ld) begin
            cap_addr <= req_addr;
            cap_wr   <= req_wr;
         end
         if (wb_ld) begin
            wb_addr <= wb_ld_addr;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      index_nxt   = index;
      cap_ld      = 1'b0;
      wb_ld       = 1'b0;
      wb_ld_addr  = '0;
      done_nxt    = 1'b0;
      hit_nxt     = 1'b0;
      fdone_nxt   = 1'b0;
      tag_rd_sel  = cap_idx;
      tag_wr_sel  = cap_idx;
      tag_wr_data = '0;
      tag_wr_ena  = 1'b0;
      wb_req      = 1'b0;
      lf_req      = 1'b0;

      unique case (state)
         // Tag RAM has no reset of its own: clear every entry once.
         S_INIT: begin
            tag_rd_sel = index;
            tag_wr_sel = index;
            tag_wr_ena = 1'b1;
            index_nxt  = index + LSS'(1);
            if (index == LSS'(NL - 1)) begin
               state_nxt = S_IDLE;
            end
         end

         // Read select is driven straight from the request address so the
         // tag is back in the very next cycle (LOOKUP).
         S_IDLE: begin
            tag_rd_sel = req_addr[LSH:5];
            if (flush_req) begin
               state_nxt = S_FL_RD;
            end else if (req) begin
               cap_ld    = 1'b1;
               state_nxt = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (tag_match) begin
               done_nxt  = 1'b1;
               hit_nxt   = 1'b1;
               state_nxt = S_IDLE;
               // Store hit on a clean line: mark it dirty.
               if (cap_wr && !rd_d) begin
                  tag_wr_ena  = 1'b1;
                  tag_wr_data = {1'b1, 1'b1, cap_tag};
               end
            end else if (rd_v && rd_d) begin
               wb_ld      = 1'b1;
               wb_ld_addr = {rd_tag, cap_idx, 5'b0};
               state_nxt  = S_WB;
            end else begin
               state_nxt = S_LF;
            end
         end

         S_WB: begin
            wb_req = 1'b1;
            if (wb_ack) begin
               state_nxt = S_LF;
            end
         end

         S_LF: begin
            lf_req = 1'b1;
            if (lf_ack) begin
               state_nxt = S_ALLOC;
            end
         end

         S_ALLOC: begin
            tag_wr_ena  = 1'b1;
            tag_wr_data = {1'b1, cap_wr, cap_tag};
            done_nxt    = 1'b1;
            state_nxt   = S_IDLE;
         end

         // Flush sweep: index is 0 on entry (it wraps at the end of INIT and
         // of every previous sweep).
         S_FL_RD: begin
            tag_rd_sel = index;
            tag_wr_sel = index;
            state_nxt  = S_FL_CHK;
         end

         S_FL_CHK: begin
            tag_rd_sel = index;
            tag_wr_sel = index;
            if (rd_v && rd_d) begin
               wb_ld      = 1'b1;
               wb_ld_addr = {rd_tag, index, 5'b0};
               state_nxt  = S_FL_WB;
            end else begin
               state_nxt = S_FL_INV;
            end
         end

         S_FL_WB: begin
            tag_rd_sel = index;
            tag_wr_sel = index;
            wb_req     = 1'b1;
            if (wb_ack) begin
               state_nxt = S_FL_INV;
            end
         end

         S_FL_INV: begin
            tag_rd_sel = index;
            tag_wr_sel = index;
            tag_wr_ena = 1'b1;
            index_nxt  = index + LSS'(1);
            if (index == LSS'(NL - 1)) begin
               fdone_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_FL_RD;
            end
         end

         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

endmodule
